// File: rtl/pipelined_subtractor.sv
// Pipelined (WIDTH+1)-bit subtractor: borrow ripples one CHUNK-bit slice per register stage.
// Optional macro SUBTRACTOR_SATURATE_EN clamps diff to zero whenever borrow is set.
module pipelined_subtractor #(
    parameter int WIDTH = 127,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);
    localparam int DW     = WIDTH + 1;
    localparam int NCHUNK = (DW + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;

    // Handshake: a beat moves on in_valid & in_ready and leaves on out_valid & out_ready.
    // The whole pipe advances together; when the output is stalled every stage holds.
    logic w_adv;

    // Stage 0 is the input register; stage k holds slices [0..k-1] already resolved in
    // r_a, with the untouched upper minuend bits still in place above them.
    logic [PW-1:0] r_a  [0:NCHUNK];
    logic [PW-1:0] r_b  [0:NCHUNK-1];
    logic          r_bw [0:NCHUNK];
    logic          r_v  [0:NCHUNK];

    logic [CHUNK:0] w_sub    [1:NCHUNK];
    logic [PW-1:0]  w_a_next [1:NCHUNK];

    assign w_adv     = !r_v[NCHUNK] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[NCHUNK];
    assign diff      = r_a[NCHUNK][DW-1:0];
    assign borrow    = r_bw[NCHUNK];

    // Zero padding above bit WIDTH propagates the borrow unchanged, so the top
    // slice's borrow out equals the borrow out of bit WIDTH even for a partial slice.
    always_comb begin
        for (int k = 1; k <= NCHUNK; k++) begin
            w_sub[k] = {1'b0, r_a[k-1][(k-1)*CHUNK +: CHUNK]}
                     - {1'b0, r_b[k-1][(k-1)*CHUNK +: CHUNK]}
                     - {{CHUNK{1'b0}}, r_bw[k-1]};
            w_a_next[k] = r_a[k-1];
            w_a_next[k][(k-1)*CHUNK +: CHUNK] = w_sub[k][CHUNK-1:0];
        end
`ifdef SUBTRACTOR_SATURATE_EN
        if (w_sub[NCHUNK][CHUNK]) begin
            w_a_next[NCHUNK] = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NCHUNK; k++) begin
                r_v[k]  <= 1'b0;
                r_a[k]  <= '0;
                r_bw[k] <= 1'b0;
            end
            for (int k = 0; k < NCHUNK; k++) begin
                r_b[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[0]  <= in_valid;
            r_a[0]  <= PW'(minuend);
            r_b[0]  <= PW'(subtrahend);
            r_bw[0] <= 1'b0;
            for (int k = 1; k <= NCHUNK; k++) begin
                r_v[k]  <= r_v[k-1];
                r_a[k]  <= w_a_next[k];
                r_bw[k] <= w_sub[k][CHUNK];
            end
            for (int k = 1; k < NCHUNK; k++) begin
                r_b[k] <= r_b[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: directed table, stall/reset sequences,
// and a randomized valid/ready stream scored against a plain-arithmetic model.
module tb_pipelined_subtractor;
    localparam int W  = 127;
    localparam int DW = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] minuend = '0;
    logic [W-1:0]  subtrahend = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] diff;
    logic          borrow;

    always #5 clk = ~clk;

    pipelined_subtractor #(.WIDTH(W), .CHUNK(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .minuend(minuend), .subtrahend(subtrahend),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
    );

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q[$];
    logic        acc = 1'b0;
    logic        drn = 1'b0;
    logic        rdy_seen = 1'b0;
    logic        stall_prev = 1'b0;
    logic [DW:0] held = '0;

    typedef struct {
        logic [DW-1:0] m;
        logic [W-1:0]  s;
        logic [DW-1:0] d;
        logic          b;
    } vec_t;
    vec_t tbl[9];

    // Reference: unsigned subtraction one bit wider than the operands; the extra bit is the borrow.
    function automatic logic [DW:0] ref_sub(input logic [DW-1:0] m, input logic [W-1:0] s);
        logic [DW:0] r;
        r = {1'b0, m} - {2'b00, s};
`ifdef SUBTRACTOR_SATURATE_EN
        if (r[DW]) r[DW-1:0] = '0;
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] m, input logic [W-1:0] s,
                         input logic ordy, input logic [DW:0] e);
        in_valid   = iv;
        minuend    = m;
        subtrahend = s;
        out_ready  = ordy;
        #1;
        if (stall_prev) begin
            check_bit("hold_valid", out_valid, 1'b1);
            check("hold_data", {borrow, diff}, held);
        end
        check_bit("in_ready", in_ready, !out_valid || ordy);
        rdy_seen = in_ready;
        drn = out_valid && ordy;
        acc = iv && in_ready;
        if (drn) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%h expected=none", {borrow, diff});
            end else begin
                check("data", {borrow, diff}, exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(e);
        stall_prev = out_valid && !ordy;
        held = {borrow, diff};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle(1'b0, '0, '0, 1'b1, '0);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 beats left", exp_q.size());
        end
    endtask

    task automatic latency_test(input logic [DW-1:0] m, input logic [W-1:0] s, input string name);
        int first = -1;
        cycle(1'b1, m, s, 1'b1, ref_sub(m, s));
        for (int n = 1; n <= 20; n++) begin
            cycle(1'b0, '0, '0, 1'b1, '0);
            if (drn && first < 0) first = n;
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL %s actual=%0d expected=5 cycles", name, first);
        end
    endtask

    initial begin
        tbl[0] = '{m: DW'(5), s: W'(3), d: DW'(2), b: 1'b0};
        tbl[1] = '{m: (DW'(1) << 127) + DW'(7), s: W'(1) << 126, d: (DW'(1) << 126) + DW'(7), b: 1'b0};
        tbl[2] = '{m: DW'(1) << 96, s: W'(1), d: (DW'(1) << 96) - DW'(1), b: 1'b0};
        tbl[3] = '{m: DW'(12345), s: W'(12345), d: DW'(0), b: 1'b0};
        tbl[4] = '{m: DW'(1) << 32, s: W'(1), d: DW'(32'hffff_ffff), b: 1'b0};
        tbl[5] = '{m: {DW{1'b1}}, s: {W{1'b1}}, d: DW'(1) << 127, b: 1'b0};
        tbl[6] = '{m: DW'(1) << 64, s: W'(1) << 32, d: (DW'(1) << 64) - (DW'(1) << 32), b: 1'b0};
`ifdef SUBTRACTOR_SATURATE_EN
        tbl[7] = '{m: DW'(3), s: W'(5), d: DW'(0), b: 1'b1};
        tbl[8] = '{m: DW'(0), s: {W{1'b1}}, d: DW'(0), b: 1'b1};
`else
        tbl[7] = '{m: DW'(3), s: W'(5), d: ~DW'(1), b: 1'b1};
        tbl[8] = '{m: DW'(0), s: {W{1'b1}}, d: (DW'(1) << 127) + DW'(1), b: 1'b1};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", {borrow, diff}, '0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First-beat latency, 5 - 3
        latency_test(DW'(5), W'(3), "latency");
        drain(20);

        // Directed table, back to back
        foreach (tbl[i]) cycle(1'b1, tbl[i].m, tbl[i].s, 1'b1, {tbl[i].b, tbl[i].d});
        drain(40);

        // Ten beats with output stalled on cycles 7-9
        begin
            int sent = 0;
            int cyc = 0;
            logic [DW-1:0] m;
            logic [W-1:0] s;
            logic ordy;
            m = rnd();
            s = W'(rnd());
            while (sent < 10 && cyc < 60) begin
                ordy = !(cyc >= 6 && cyc <= 8);
                cycle(1'b1, m, s, ordy, ref_sub(m, s));
                if (cyc >= 6 && cyc <= 8) check_bit("stall_in_ready", rdy_seen, 1'b0);
                if (acc) begin
                    sent++;
                    m = rnd();
                    s = W'(rnd());
                end
                cyc++;
            end
            check("stall_sent", DW'(sent), DW'(10));
            drain(60);
        end

        // Random stream with random valid/ready
        begin
            int sent = 0;
            int cyc = 0;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [DW-1:0] m;
            logic [DW:0] e;
            while (sent < 10000 && cyc < 60000) begin
                a = W'(rnd());
                b = W'(rnd());
                if ($urandom_range(0, 3) == 0) begin
                    m = rnd();
                    e = ref_sub(m, b);
                end else begin
                    m = {1'b0, a} + {1'b0, b};
                    e = {2'b00, a};
                end
                cycle($urandom_range(0, 3) != 0, m, b, $urandom_range(0, 3) != 0, e);
                if (acc) sent++;
                cyc++;
            end
            check("random_sent", DW'(sent), DW'(10000));
            drain(100);
        end

        // Mid-stream reset with beats in flight and the output stalled
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] m;
            logic [W-1:0] s;
            m = rnd();
            s = W'(rnd());
            cycle(1'b1, m, s, 1'b0, ref_sub(m, s));
        end
        check_bit("pre_rst_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", {borrow, diff}, '0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_bit("no_stale", out_valid, 1'b0);
            cycle(1'b0, '0, '0, 1'b1, '0);
        end
        latency_test(DW'(1) << 96, W'(1), "latency_after_rst");
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
